// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmit path.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int UART_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_ctr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_r;

  // Count register: synchronous clear, wrap to zero after terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_r == TC) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign count = count_r;
  assign tick  = (count_r == TC);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serialises each byte as a
// UART 8N1 frame, LSB first, on a registered tx line.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = UART_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] PRE_TC = CW'(CLKS_PER_BIT - 2);

  uart_state_t       state_r;
  uart_state_t       next_state_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_next_s;
  logic [2:0]        bit_cnt_r;
  logic              tx_r;
  logic              tx_next_s;
  logic              busy_r;
  logic              frame_done_r;
  logic              rd_en_s;
  logic              baud_clr_s;
  logic              baud_tick_s;
  logic [CW-1:0]     baud_cnt_s;

  assign baud_clr_s = (state_r == IDLE) || (state_r == FETCH);

  uart_baud_ctr #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CW)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr   (baud_clr_s),
    .count (baud_cnt_s),
    .tick  (baud_tick_s)
  );

  // Next state, next shift value and the tx level the next state will drive
  always_comb begin
    next_state_s = state_r;
    shift_next_s = shift_r;
    rd_en_s      = 1'b0;
    tx_next_s    = 1'b1;
    case (state_r)
      IDLE: begin
        if (enable && !fifo_empty) begin
          rd_en_s      = 1'b1;
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        shift_next_s = fifo_rdata;
        next_state_s = START;
      end
      START: begin
        if (baud_tick_s) begin
          next_state_s = DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          shift_next_s = {1'b0, shift_r[DATA_W-1:1]};
          if (bit_cnt_r == 3'd7) begin
            next_state_s = STOP;
          end else begin
            next_state_s = DATA;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      STOP: begin
        if (baud_tick_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // tx is registered from the upcoming state so it changes exactly on entry
    case (next_state_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      default: tx_next_s = 1'b1;
    endcase
  end

  // State, datapath and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= {DATA_W{1'b0}};
      bit_cnt_r    <= 3'd0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      shift_r      <= shift_next_s;
      tx_r         <= tx_next_s;
      busy_r       <= (next_state_s != IDLE);
      // one cycle early so the pulse lands on the last stop-bit cycle
      frame_done_r <= (state_r == STOP) && (baud_cnt_s == PRE_TC);
      if (state_r == FETCH) begin
        bit_cnt_r <= 3'd0;
      end else if ((state_r == DATA) && baud_tick_s && (bit_cnt_r != 3'd7)) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign fifo_rd_en = rd_en_s && !rst;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: scenario table, hand-checked frames,
// then random traffic against a frame-level reference model.
module tb_fifo_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 10 * N;
  localparam int NSTEP = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata;
  logic       tx;
  logic       busy;
  logic       frame_done;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       enable;
    int         npush;
    logic [7:0] b0;
    logic [7:0] b1;
    int         exp_pops;
    int         exp_dones;
  } step_t;

  step_t      steps[NSTEP];
  int         step_start[NSTEP];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         step_pops;
  int         step_dones;
  logic [7:0] fifo_q[$];
  logic       tx_log[$];
  logic       busy_log[$];
  logic       done_log[$];
  logic       rd_log[$];

  // Reference model: idle, or k cycles after the pop of m_byte
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[i-1];
    else return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle();
    logic [3:0] exp_v;
    logic [3:0] act_v;
    logic       popped;
    @(negedge clk);
    if (!m_active) begin
      exp_v = {1'b1, 1'b0, 1'b0, (enable && (fifo_q.size() != 0) && !rst)};
    end else begin
      exp_v = {((m_k == 1) ? 1'b1 : frame_bit(m_byte, (m_k - 2) / N)),
               1'b1, (m_k == FRAME + 1), 1'b0};
    end
    act_v = {tx, busy, frame_done, fifo_rd_en};
    check("tx_busy_done_rden", {28'd0, act_v}, {28'd0, exp_v});
    tx_log.push_back(tx);
    busy_log.push_back(busy);
    done_log.push_back(frame_done);
    rd_log.push_back(fifo_rd_en);
    if (fifo_rd_en) step_pops++;
    if (frame_done) step_dones++;
    popped = fifo_rd_en;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (exp_v[0]) begin
        m_active = 1'b1;
        m_k      = 1;
        m_byte   = fifo_q[0];
      end
    end else begin
      m_k++;
      if (m_k > FRAME + 1) m_active = 1'b0;
    end
    #1;
    if (popped && (fifo_q.size() != 0)) fifo_rdata = fifo_q.pop_front();
    else fifo_rdata = 8'($urandom);
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  initial begin
    logic a5_pat[10];
    logic acc;
    int   s1;
    int   s2;
    a5_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    //           cycles rst   en    np  b0     b1     pops dones
    steps[0]  = '{2,   1'b1, 1'b1, 1, 8'hA5, 8'h00, 0, 0};  // reset with data waiting
    steps[1]  = '{45,  1'b0, 1'b1, 0, 8'h00, 8'h00, 1, 1};  // single 0xA5
    steps[2]  = '{90,  1'b0, 1'b1, 2, 8'h00, 8'hFF, 2, 2};  // back-to-back
    steps[3]  = '{100, 1'b0, 1'b0, 1, 8'h5A, 8'h00, 0, 0};  // disabled, non-empty
    steps[4]  = '{1,   1'b0, 1'b1, 0, 8'h00, 8'h00, 1, 0};  // enable -> immediate pop
    steps[5]  = '{44,  1'b0, 1'b0, 0, 8'h00, 8'h00, 0, 1};  // enable dropped mid-frame
    steps[6]  = '{200, 1'b0, 1'b1, 0, 8'h00, 8'h00, 0, 0};  // empty FIFO
    steps[7]  = '{20,  1'b0, 1'b1, 1, 8'h3C, 8'h00, 1, 0};  // run into data bit 3
    steps[8]  = '{1,   1'b1, 1'b1, 0, 8'h00, 8'h00, 0, 0};  // reset mid-frame
    steps[9]  = '{60,  1'b0, 1'b1, 0, 8'h00, 8'h00, 0, 0};  // stays idle
    steps[10] = '{45,  1'b0, 1'b1, 1, 8'h81, 8'h00, 1, 1};  // recovery byte

    fifo_rdata = 8'h00;
    for (int s = 0; s < NSTEP; s++) begin
      rst    = steps[s].rst;
      enable = steps[s].enable;
      if (steps[s].npush > 0) fifo_q.push_back(steps[s].b0);
      if (steps[s].npush > 1) fifo_q.push_back(steps[s].b1);
      fifo_empty    = (fifo_q.size() == 0);
      step_pops     = 0;
      step_dones    = 0;
      step_start[s] = cyc;
      repeat (steps[s].cycles) run_cycle();
      check($sformatf("step%0d_pops", s), 32'(step_pops), 32'(steps[s].exp_pops));
      check($sformatf("step%0d_dones", s), 32'(step_dones), 32'(steps[s].exp_dones));
    end

    // 0xA5 frame against the literal bit pattern
    s1 = step_start[1];
    check("first_pop_after_reset", {31'd0, rd_log[s1]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i),
            {28'd0, tx_log[s1+2+N*i], tx_log[s1+3+N*i], tx_log[s1+4+N*i], tx_log[s1+5+N*i]},
            {28'd0, {4{a5_pat[i]}}});
    end
    check("a5_done_cycle40", {31'd0, done_log[s1+1+FRAME]}, 32'd1);
    check("a5_busy_fall", {30'd0, busy_log[s1+1+FRAME], busy_log[s1+2+FRAME]}, 32'd2);

    // back-to-back gap and all-ones second frame
    s2 = step_start[2];
    check("b2b_gap_high", {29'd0, tx_log[s2+41], tx_log[s2+42], tx_log[s2+43]}, 32'd7);
    check("b2b_second_start", {31'd0, tx_log[s2+44]}, 32'd0);
    acc = 1'b1;
    for (int i = s2 + 48; i < s2 + 80; i++) acc = acc & tx_log[i];
    check("b2b_ff_data_ones", {31'd0, acc}, 32'd1);

    // reset mid-frame: line idle immediately afterwards
    check("reset_mid_tx_busy", {30'd0, tx_log[step_start[9]], busy_log[step_start[9]]}, 32'd2);

    // random traffic against the model
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if (($urandom_range(0, 29) == 0) && (fifo_q.size() < 8)) fifo_q.push_back(8'($urandom));
      fifo_empty = (fifo_q.size() == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the project's byte FIFO. It pops one byte at a time whenever the FIFO is non-empty and enabled, and serialises each byte onto a single UART 8N1 line, LSB first. It sits between the FIFO read port and the `uo_out` pin mapping of the top-level tile.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥ 2.
- `DATA_W`, default 8: byte width; fixed at 8 for 8N1.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new frames to start; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  one-cycle pop strobe to the FIFO.
- `fifo_rdata`  in  8  FIFO read data, valid the cycle after `fifo_rd_en`.
- `tx`  out  1  UART serial line; idle high.
- `busy`  out  1  high from FETCH through the end of STOP.
- `frame_done`  out  1  one-cycle pulse in the last cycle of STOP.

## Operation
- FSM states: IDLE, FETCH, START, DATA, STOP.
- IDLE: `fifo_rd_en` = `enable && !fifo_empty` (combinational, only in IDLE). When it is high, the next state is FETCH.
- FETCH, one cycle:
  - Latch `fifo_rdata` into an 8-bit shift register.
  - Clear the baud and bit counters.
  - Next state is START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - `tx` = shift_reg[0].
  - Each CLKS_PER_BIT cycles, shift right and increment the bit counter (0..7).
  - After bit 7 completes, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `frame_done` pulses in the final cycle. Next state is IDLE.
- `enable` dropping mid-frame has no effect on that frame. Only new frame starts are blocked.
- `fifo_empty` is ignored outside IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, and the bit period ends on terminal count.
- Bit counter: 3 bits, no wrap beyond 7.
- `tx` is registered; it is driven from a flop, never a decode glitch.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0, state IDLE, counters 0, shift register 0.
- `fifo_rd_en` high in cycle c gives:
  - FETCH in c+1;
  - `tx` low from c+2.
- Frame length is exactly 10·CLKS_PER_BIT cycles of `tx` (start, 8 data, stop).
- Back-to-back frames with a continuously non-empty FIFO have 2 extra `tx`-high cycles (IDLE and FETCH) between the stop bit and the next start bit. The period is 10·CLKS_PER_BIT+2 cycles.
- `busy` rises in FETCH and falls on entry to IDLE.
- Reset asserted mid-frame:
  - Next cycle `tx`=1 and state is IDLE.
  - The in-flight byte is discarded, not re-popped.
  - No `frame_done` pulse.
- `rst` and any other input high in the same cycle: reset wins.
- FIFO goes empty during a frame: the frame completes and the FSM stays in IDLE until data arrives.

## Structure
- Package `fifo_uart_pkg`:
  - state enum `uart_state_t`;
  - `UART_BITS`=8;
  - default `CLKS_PER_BIT_DEF`=16.
- Sub-module `uart_baud_ctr`: parameterised CLKS_PER_BIT counter with synchronous clear and a `tick` terminal-count output. It is reused by a future RX stage.
- Top-level FSM, shift register and bit counter live in `fifo_uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert `rst` 2 cycles with `fifo_empty`=0 and `enable`=1. Required response:
  - during reset, `tx`=1, `busy`=0, `fifo_rd_en`=0;
  - first pop in the cycle after `rst` falls.
- Single byte 0xA5: `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. Required response:
  - `frame_done` pulses once in cycle 40 of the frame;
  - `busy` falls the cycle after.
- Back-to-back 0x00 then 0xFF: exactly 2 high cycles between the first stop bit and the second start bit. Required response:
  - `fifo_rd_en` pulses exactly twice;
  - second frame data bits all 1.
- `enable`=0 with non-empty FIFO: no `fifo_rd_en` and `tx` stays 1 for 100 cycles. Raising `enable` pops within 1 cycle. Lowering `enable` mid-frame still completes the frame.
- Reset at data bit 3 of 0x3C: `tx`=1 the next cycle, no `frame_done`. With the FIFO then empty, the line stays idle. The next pushed byte 0x81 transmits correctly.
- Empty FIFO throughout: `fifo_rd_en` never asserts, `tx`=1 and `busy`=0 for 200 cycles.
